// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module : crc_pkg
// Brief  : Default CRC-32 constants, stream FSM state encoding and bit helper.
// Rev    : 1.0  initial release
// ============================================================================
package crc_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_byte_step.sv
`default_nettype none
// ============================================================================
// Module : crc_byte_step
// Brief  : Combinational one-byte CRC update; register is kept in normal form.
// Rev    : 1.0  initial release
// ============================================================================
module crc_byte_step
    import crc_pkg::*;
#(
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter int          REFLECT = 1
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    // Reflected mode feeds the byte LSB-first into a normal-form register,
    // so the reflected result is just a bit reversal of this register.
    function automatic logic [31:0] f_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        bit_in;
        c      = c_in;
        bit_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_in = (REFLECT != 0) ? b[i] : b[7-i];
            if (c[31] ^ bit_in) begin
                c = (c << 1) ^ POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

    assign crc_out = f_step(crc_in, byte_in);

endmodule
`default_nettype wire

// File: rtl/crc_stream.sv
`default_nettype none
// ============================================================================
// Module : crc_stream
// Brief  : Streaming CRC over framed beats with length count and residue check.
//          Optional residue compare enabled by macro CRC_STREAM_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module crc_stream
    import crc_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] XOR_OUT = CRC32_XOR_OUT,
    parameter int          REFLECT = 1,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_keep,
    input  logic                  s_sop,
    input  logic                  s_eop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_crc,
    output logic [15:0]           m_len,
    output logic                  m_good
);

    localparam int c_NBYTES = DATA_W / 8;

    state_t                r_state;
    logic [31:0]           r_crc;
    logic [15:0]           r_len;

    logic                  w_accept;
    logic [c_NBYTES-1:0]   w_en;
    logic                  w_run;
    logic [3:0]            w_cnt;
    logic [31:0]           w_seed;
    logic [31:0]           w_crc_nxt;
    logic [31:0]           w_crc_final;
    logic [15:0]           w_len_start;
    logic [16:0]           w_len_sum;
    logic [15:0]           w_len_nxt;
    logic                  w_good_nxt;

    assign w_accept = s_valid && s_ready;

    // Non-eop beats take every byte; the eop beat takes only the lowest keep run.
    always_comb begin
        w_en  = '0;
        w_cnt = '0;
        w_run = 1'b1;
        for (int i = 0; i < c_NBYTES; i++) begin
            w_run   = w_run && (!s_eop || s_keep[i]);
            w_en[i] = w_run;
            w_cnt   = w_cnt + {3'b000, w_run};
        end
    end

    assign w_seed = s_sop ? INIT : r_crc;

    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_byte
        logic [31:0] w_in;
        logic [31:0] w_out;
        logic [31:0] w_nxt;

        if (gi == 0) begin : g_first
            assign w_in = w_seed;
        end else begin : g_rest
            assign w_in = g_byte[gi-1].w_nxt;
        end

        crc_byte_step #(
            .POLY    (POLY),
            .REFLECT (REFLECT)
        ) u_step (
            .crc_in  (w_in),
            .byte_in (s_data[8*gi +: 8]),
            .crc_out (w_out)
        );

        assign w_nxt = w_en[gi] ? w_out : w_in;
    end

    assign w_crc_nxt   = g_byte[c_NBYTES-1].w_nxt;
    assign w_crc_final = (REFLECT != 0) ? bitrev32(w_crc_nxt) : w_crc_nxt;

    assign w_len_start = s_sop ? 16'd0 : r_len;
    assign w_len_sum   = {1'b0, w_len_start} + {13'd0, w_cnt};
    assign w_len_nxt   = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

`ifdef CRC_STREAM_CHECK_EN
    assign w_good_nxt = (w_crc_final == RESIDUE);
`else
    logic w_unused_residue;
    assign w_unused_residue = ^RESIDUE;
    assign w_good_nxt       = 1'b0;
`endif

    // A sop beat is honoured in both IDLE and RUN, which also covers abort/restart.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state <= ST_IDLE;
            s_ready <= 1'b1;
            r_crc   <= INIT;
            r_len   <= 16'd0;
            m_valid <= 1'b0;
            m_crc   <= 32'd0;
            m_len   <= 16'd0;
            m_good  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_accept && (s_sop || (r_state == ST_RUN))) begin
                        if (s_eop) begin
                            r_state <= ST_HOLD;
                            s_ready <= 1'b0;
                            m_valid <= 1'b1;
                            m_crc   <= w_crc_final ^ XOR_OUT;
                            m_len   <= w_len_nxt;
                            m_good  <= w_good_nxt;
                        end else begin
                            r_state <= ST_RUN;
                            r_crc   <= w_crc_nxt;
                            r_len   <= w_len_nxt;
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_state <= ST_IDLE;
                        s_ready <= 1'b1;
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_crc_stream
// Brief  : Scoreboard bench for crc_stream against a byte-list CRC-32 model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_crc_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_valid, s_ready, s_sop, s_eop;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        m_valid, m_ready, m_good;
    logic [31:0] m_crc;
    logic [15:0] m_len;

    logic        s8_valid, s8_ready, s8_sop, s8_eop;
    logic [7:0]  s8_data;
    logic [0:0]  s8_keep;
    logic        m8_valid, m8_ready, m8_good;
    logic [31:0] m8_crc;
    logic [15:0] m8_len;

    crc_stream #(.DATA_W(32)) dut (
        .clk(clk), .reset_p(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
        .s_sop(s_sop), .s_eop(s_eop),
        .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .m_len(m_len), .m_good(m_good)
    );

    crc_stream #(.DATA_W(8)) dut8 (
        .clk(clk), .reset_p(rst),
        .s_valid(s8_valid), .s_ready(s8_ready), .s_data(s8_data), .s_keep(s8_keep),
        .s_sop(s8_sop), .s_eop(s8_eop),
        .m_valid(m8_valid), .m_ready(m8_ready), .m_crc(m8_crc), .m_len(m8_len), .m_good(m8_good)
    );

    typedef struct {
        logic [31:0] crc;
        logic [15:0] len;
        logic        good;
        int          cyc;
    } exp_t;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    exp_t         q[$];
    byte unsigned m_frame[$];
    bit           m_in = 1'b0;
    bit           hold_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Textbook reflected CRC-32 over the list of absorbed bytes.
    function automatic exp_t model(input byte unsigned d[$]);
        exp_t        e;
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        e.crc = c ^ 32'hFFFFFFFF;
        e.len = (d.size() > 65535) ? 16'hFFFF : 16'(d.size());
`ifdef CRC_STREAM_CHECK_EN
        e.good = (c == 32'hDEBB20E3);
`else
        e.good = 1'b0;
`endif
        e.cyc = 0;
        return e;
    endfunction

    task automatic apply_beat(input logic [31:0] d, input logic [3:0] k, input logic sop, input logic eop);
        int   n;
        exp_t e;
        if (sop) begin
            m_frame.delete();
            m_in = 1'b1;
        end
        if (!m_in) return;
        n = 4;
        if (eop) begin
            n = 0;
            while (n < 4 && k[n]) n++;
        end
        for (int i = 0; i < n; i++) m_frame.push_back(d[8*i +: 8]);
        if (eop) begin
            e     = model(m_frame);
            e.cyc = cyc;
            q.push_back(e);
            m_in  = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic sop, input logic eop);
        int w;
        w = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_keep = k; s_sop = sop; s_eop = eop;
        while (!s_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            n_chk++; n_fail++;
            $display("FAIL s_ready_timeout: got 0 expected 1 within 300 cycles");
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        apply_beat(d, k, sop, eop);
    endtask

    task automatic send_frame(input byte unsigned d[$], input bit gaps);
        int          n, i, rem;
        logic [31:0] w;
        logic [3:0]  k;
        bit          zt, last;
        n  = d.size();
        i  = 0;
        zt = (n % 4 == 0) && ($urandom_range(0, 3) == 0);
        while (i < n) begin
            rem = n - i;
            w   = $urandom;
            for (int j = 0; j < 4; j++) if (j < rem) w[8*j +: 8] = d[i+j];
            last = (rem <= 4) && !zt;
            if (last) begin
                k = '0;
                for (int j = 0; j < 4; j++) if (j < rem) k[j] = 1'b1;
                if (rem <= 2 && $urandom_range(0, 1) == 1) k[rem+1] = 1'b1;
            end else begin
                k = 4'($urandom);
            end
            drive_beat(w, k, (i == 0), last);
            i += 4;
            if (gaps && $urandom_range(0, 4) == 0) @(negedge clk);
        end
        if (zt) drive_beat($urandom, 4'h0, 1'b0, 1'b1);
    endtask

    // Monitor: pops one expectation per presented result, then tracks the hold.
    initial begin
        bit   seen;
        bit   prev_rdy;
        int   hold_cnt;
        exp_t cur;
        seen = 0; prev_rdy = 0; hold_cnt = 0;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (seen && !prev_rdy) chk("hold_valid", m_valid, 1);
            if (!m_valid) begin
                seen = 0;
            end else if (!seen) begin
                seen = 1;
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result: got crc %h expected no result", m_crc);
                    cur.crc = m_crc; cur.len = m_len; cur.good = m_good;
                end else begin
                    cur = q.pop_front();
                    chk("crc", m_crc, cur.crc);
                    chk("len", m_len, cur.len);
                    chk("good", m_good, cur.good);
                    chk("latency_cycle", cyc, cur.cyc);
                end
                chk("s_ready_in_hold", s_ready, 0);
                if (hold_req) begin
                    hold_cnt = 5;
                    hold_req = 0;
                end
            end else begin
                chk("hold_crc", m_crc, cur.crc);
                chk("hold_len", m_len, cur.len);
                chk("hold_s_ready", s_ready, 0);
            end
            if (hold_cnt > 0) begin
                m_ready = 1'b0;
                hold_cnt--;
            end else begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
            prev_rdy = m_ready;
        end
    end

    initial begin
        byte unsigned ascii[$];
        byte unsigned d[$];
        int           bi, w;

        rst = 1'b1;
        s_valid = 0; s_data = 0; s_keep = 0; s_sop = 0; s_eop = 0;
        s8_valid = 0; s8_data = 0; s8_keep = 0; s8_sop = 0; s8_eop = 0;
        m8_ready = 1'b1;
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_crc", m_crc, 0);
        chk("rst_m_len", m_len, 0);
        chk("rst_m_good", m_good, 0);
        rst = 1'b0;

        // 8-bit instance: check vector as nine single-byte beats
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s8_valid = 1'b1; s8_data = ascii[i]; s8_keep = 1'b1;
            s8_sop = (i == 0); s8_eop = (i == 8);
            @(posedge clk);
            #1;
        end
        s8_valid = 1'b0;
        @(negedge clk);
        chk("w8_valid", m8_valid, 1);
        chk("w8_crc", m8_crc, 32'hCBF43926);
        chk("w8_len", m8_len, 9);

        // 32-bit: check vector as three beats, final keep 0001
        send_frame(ascii, 1'b0);
        q[q.size()-1].crc = 32'hCBF43926;
        q[q.size()-1].len = 16'd9;

        // Residue: data followed by its own CRC, then single-bit corruptions
        d = ascii;
        d.push_back(8'h26); d.push_back(8'h39); d.push_back(8'hF4); d.push_back(8'hCB);
        send_frame(d, 1'b1);
`ifdef CRC_STREAM_CHECK_EN
        q[q.size()-1].good = 1'b1;
`endif
        for (int t = 0; t < 3; t++) begin
            d = ascii;
            d.push_back(8'h26); d.push_back(8'h39); d.push_back(8'hF4); d.push_back(8'hCB);
            bi = $urandom_range(0, 103);
            d[bi/8] = d[bi/8] ^ (8'h01 << (bi % 8));
            send_frame(d, 1'b1);
            q[q.size()-1].good = 1'b0;
        end

        // Back-pressure: stall the next result for five cycles, then continue
        hold_req = 1'b1;
        send_frame(ascii, 1'b0);
        send_frame(ascii, 1'b1);

        // Abort: new sop two beats into a frame
        drive_beat($urandom, 4'hF, 1'b1, 1'b0);
        drive_beat($urandom, 4'($urandom), 1'b0, 1'b0);
        d.delete();
        for (int i = 0; i < 7; i++) d.push_back(8'($urandom));
        send_frame(d, 1'b1);

        // Random frames with stray non-sop beats between them
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0)
                drive_beat($urandom, 4'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            d.delete();
            w = $urandom_range(1, 24);
            for (int i = 0; i < w; i++) d.push_back(8'($urandom));
            send_frame(d, 1'b1);
        end

        // Length saturation
        d.delete();
        for (int i = 0; i < 65600; i++) d.push_back(8'($urandom));
        send_frame(d, 1'b0);

        // Reset mid-frame
        w = 0;
        while ((q.size() != 0 || m_valid) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        drive_beat($urandom, 4'hF, 1'b1, 1'b0);
        drive_beat($urandom, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        m_in = 1'b0;
        m_frame.delete();
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_m_valid", m_valid, 0);
        end
        chk("postrst_s_ready", s_ready, 1);
        send_frame(ascii, 1'b1);

        w = 0;
        while (q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the input width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter POLY, default 32'h04C11DB7, giving the normal-form generator polynomial.
REQ-003 SHALL have parameter INIT, default 32'hFFFFFFFF, giving the register value at frame start.
REQ-004 SHALL have parameter XOR_OUT, default 32'hFFFFFFFF, XORed into the register to form m_crc.
REQ-005 SHALL have parameter REFLECT, default 1; 1 means input bytes are processed LSB-first and the output is bit-reflected.
REQ-006 SHALL have parameter RESIDUE, default 32'hDEBB20E3, giving the good-frame residue in the output domain before XOR_OUT.
REQ-007 SHALL have one clock and an asynchronous, active-high reset; the ports are clk and reset_p.
REQ-008 SHALL provide these ports:
- clk  in  1  clock
- reset_p  in  1  asynchronous active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_W  bytes; s_data[7:0] is first on the wire
- s_keep  in  DATA_W/8  byte enables; significant on the eop beat only
- s_sop  in  1  first beat of frame
- s_eop  in  1  last beat of frame
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid && m_ready
- m_crc  out  32  final CRC value
- m_len  out  16  frame byte count, saturating at 16'hFFFF
- m_good  out  1  frame residue check passed

Function
REQ-009 SHALL run an FSM with three states:
- IDLE: waits for an accepted beat with s_sop=1.
- RUN: absorbs beats until an accepted beat with s_eop=1.
- HOLD: presents the result until m_valid && m_ready.
REQ-010 SHALL drive s_ready=1 in IDLE and RUN, and s_ready=0 in HOLD.
REQ-011 SHALL, for an accepted sop beat, seed the register with INIT before absorbing that beat's bytes in the same cycle.
REQ-012 SHALL, on non-eop beats, absorb all DATA_W/8 bytes regardless of s_keep.
REQ-013 SHALL, on the eop beat, absorb only the bytes that are contiguous from the LSB in s_keep; s_keep=0 absorbs nothing; a non-contiguous s_keep absorbs only the lowest run.
REQ-014 SHALL assert m_valid in the cycle after the eop beat is accepted, giving 1-cycle latency.
REQ-015 SHALL hold m_crc, m_len and m_good stable while in HOLD.
REQ-016 SHALL treat an accepted beat with s_sop=1 && s_eop=1 as a complete single-beat frame.
REQ-017 SHALL, on an accepted sop beat while in RUN, abort the current frame with no result and restart from that beat.
REQ-018 SHALL ignore accepted beats with s_sop=0 while in IDLE.
REQ-019 SHALL return to IDLE on the m_valid && m_ready handshake; a new sop beat may be accepted in the cycle after.
REQ-020 SHALL compute m_crc as (REFLECT ? bit-reverse(reg) : reg) ^ XOR_OUT.
REQ-021 SHALL increment m_len by the number of absorbed bytes and saturate it at 65535.

Reset
REQ-022 SHALL, while reset_p=1, force state=IDLE, register=INIT, m_valid=0, m_crc=0, m_len=0 and m_good=0, with s_ready=1.
REQ-023 SHALL discard any in-flight frame or unconsumed result when reset is asserted, with no output produced.

Configuration
REQ-024 SHALL gate the residue check with macro CRC_STREAM_CHECK_EN:
- Defined: m_good = ((REFLECT ? bit-reverse(reg) : reg) == RESIDUE) when m_valid is asserted.
- Undefined: the compare logic is absent and m_good is tied to 0.

Structure
REQ-025 SHALL place the default parameter constants (CRC32_POLY, CRC32_INIT, CRC32_XOR_OUT, CRC32_RESIDUE) and the state enumeration in package crc_pkg.
REQ-026 SHALL implement the single-byte update as combinational sub-module crc_byte_step (ports crc_in, byte_in, crc_out; POLY and REFLECT parameters), instantiated DATA_W/8 times as a chain with keep-based bypass.

Verification
REQ-027 SHALL verify, with DATA_W=8, that ASCII "123456789" sent as 9 beats yields m_crc=32'hCBF43926 and m_len=9.
REQ-028 SHALL verify, with DATA_W=32, that the same bytes sent as 3 beats with final s_keep=4'b0001 yield m_crc=32'hCBF43926, m_len=9, and m_valid exactly 1 cycle after the eop beat.
REQ-029 SHALL verify, with CRC_STREAM_CHECK_EN defined, that "123456789" followed by bytes 26 39 F4 CB yields m_good=1, and that flipping any one bit yields m_good=0.
REQ-030 SHALL verify that holding m_ready=0 for 5 cycles after a result keeps m_valid=1, s_ready=0 and m_crc stable, and that the next frame is accepted after the handshake.
REQ-031 SHALL verify that a new sop 2 beats into a frame produces only the second frame's CRC, and that asserting reset_p mid-frame produces no m_valid and returns s_ready=1.
